// File: rtl/ysyx_22050854_div_ctrl.sv
// ysyx_22050854_div_ctrl: request-side controller for the iterative divider.
// Resolves divide-by-zero and signed overflow locally, otherwise hands the
// operands to the divider core, then selects/sign-extends the result and
// returns it with its destination tag. Handles flush, including draining a
// divide the core has already accepted.
// Optional feature macro: DIV_CTRL_SHORTCUT_EN (bypass when |dividend| < |divisor|).
module ysyx_22050854_div_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic             req_word,
    input  logic [63:0]      req_src1,
    input  logic [63:0]      req_src2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic             div_valid,
    input  logic             div_ready,
    output logic [63:0]      div_dividend,
    output logic [63:0]      div_divisor,
    output logic             div_w,
    output logic             div_signed,
    input  logic             div_out_valid,
    input  logic [63:0]      div_quotient,
    input  logic [63:0]      div_remainder
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned HALF = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              sel_rem_q;
    logic              accept_c;
    logic              load_rsp_c;
    logic [XLEN-1:0]   rsp_nxt_c;
    logic [XLEN-1:0]   sel_res_c;
    logic [XLEN-1:0]   div_result_c;
    logic [XLEN-1:0]   rem_ext_c;
    logic              div_zero_c;
    logic              ovf_c;
    logic              short_c;
    logic              special_c;
    logic [XLEN-1:0]   special_data_c;

`ifdef DIV_CTRL_SHORTCUT_EN
    // Operand magnitude as an unsigned value, word-sized when word.
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x,
                                                  input logic word,
                                                  input logic sgn);
        logic [XLEN-1:0] m;
        m = word ? {HALF'(0), x[HALF-1:0]} : x;
        if (sgn) begin
            if (word && x[HALF-1]) begin
                m = {HALF'(0), HALF'(HALF'(0) - x[HALF-1:0])};
            end else if (!word && x[XLEN-1]) begin
                m = XLEN'(XLEN'(0) - x);
            end
        end
        return m;
    endfunction
`endif

    // Classify the incoming request and compute any locally resolved result.
    always_comb begin
        rem_ext_c  = req_word ? {{HALF{req_src1[HALF-1]}}, req_src1[HALF-1:0]} : req_src1;
        div_zero_c = req_word ? (req_src2[HALF-1:0] == HALF'(0)) : (req_src2 == XLEN'(0));
        ovf_c      = !req_op[0] &&
                     (req_word ? ((req_src1[HALF-1:0] == 32'h8000_0000) &&
                                  (req_src2[HALF-1:0] == 32'hFFFF_FFFF))
                               : ((req_src1 == 64'h8000_0000_0000_0000) &&
                                  (req_src2 == 64'hFFFF_FFFF_FFFF_FFFF)));
`ifdef DIV_CTRL_SHORTCUT_EN
        short_c    = !div_zero_c &&
                     (magnitude(req_src1, req_word, !req_op[0]) <
                      magnitude(req_src2, req_word, !req_op[0]));
`else
        short_c    = 1'b0;
`endif
        special_c      = div_zero_c || ovf_c || short_c;
        special_data_c = '0;
        if (div_zero_c) begin
            special_data_c = req_op[1] ? rem_ext_c : '1;
        end else if (ovf_c) begin
            special_data_c = req_op[1] ? XLEN'(0) : rem_ext_c;
        end else if (short_c) begin
            special_data_c = req_op[1] ? rem_ext_c : XLEN'(0);
        end
    end

    // Select quotient/remainder from the core; word results rebuild the upper half.
    always_comb begin
        sel_res_c    = sel_rem_q ? div_remainder : div_quotient;
        div_result_c = div_w ? {{HALF{sel_res_c[HALF-1]}}, sel_res_c[HALF-1:0]} : sel_res_c;
    end

    // Next-state and load decisions.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        load_rsp_c = 1'b0;
        rsp_nxt_c  = rsp_data;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    accept_c = 1'b1;
                    if (special_c) begin
                        state_d    = S_RESP;
                        load_rsp_c = 1'b1;
                        rsp_nxt_c  = special_data_c;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (div_ready) begin
                    state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // A result arriving with the flush is already drained.
                    state_d = div_out_valid ? S_IDLE : S_DRAIN;
                end else if (div_out_valid) begin
                    state_d    = S_RESP;
                    load_rsp_c = 1'b1;
                    rsp_nxt_c  = div_result_c;
                end
            end
            S_DRAIN: begin
                if (div_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered status/handshake outputs decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            div_valid <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            req_ready <= (state_d == S_IDLE);
            busy      <= (state_d != S_IDLE);
            div_valid <= (state_d == S_ISSUE);
            rsp_valid <= (state_d == S_RESP);
            if (load_rsp_c) begin
                rsp_data <= rsp_nxt_c;
            end
        end
    end

    // Request latches; these drive the divider operands and the response tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            div_w        <= 1'b0;
            div_signed   <= 1'b0;
            sel_rem_q    <= 1'b0;
            rsp_tag      <= '0;
        end else if (accept_c) begin
            div_dividend <= req_src1;
            div_divisor  <= req_src2;
            div_w        <= req_word;
            div_signed   <= !req_op[0];
            sel_rem_q    <= req_op[1];
            rsp_tag      <= req_tag;
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_div_ctrl.sv
// Directed bench for ysyx_22050854_div_ctrl; the bench plays the divider core.
module tb_ysyx_22050854_div_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic        req_word = 1'b0;
    logic [63:0] req_src1 = '0;
    logic [63:0] req_src2 = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        busy;
    logic        div_valid;
    logic        div_ready = 1'b0;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic        div_w;
    logic        div_signed;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_quotient = '0;
    logic [63:0] div_remainder = '0;

    int checks = 0;
    int failures = 0;

    ysyx_22050854_div_ctrl #(.TAG_W(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_word(req_word), .req_src1(req_src1), .req_src2(req_src2),
        .req_tag(req_tag), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .busy(busy),
        .div_valid(div_valid), .div_ready(div_ready),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_w(div_w), .div_signed(div_signed),
        .div_out_valid(div_out_valid), .div_quotient(div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [4:0]  tag;
        logic        special;
        logic [63:0] quo;   // what the divider core returns
        logic [63:0] rem;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [1:0] op, input logic word,
                                input logic [63:0] s1, input logic [63:0] s2,
                                input logic [4:0] tag, input logic special,
                                input logic [63:0] quo, input logic [63:0] rem,
                                input logic [63:0] exp);
        vec_t v;
        v.op = op; v.word = word; v.s1 = s1; v.s2 = s2; v.tag = tag;
        v.special = special; v.quo = quo; v.rem = rem; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        req_valid = 1'b1; req_op = v.op; req_word = v.word;
        req_src1 = v.s1; req_src2 = v.s2; req_tag = v.tag;
        step();
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string nm);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk({nm, "_rsp_valid_after"}, 64'(rsp_valid), 64'd0);
        chk({nm, "_req_ready_after"}, 64'(req_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
        drive_req(v);
        if (v.special) begin
            chk({nm, "_no_div_valid"}, 64'(div_valid), 64'd0);
        end else begin
            chk({nm, "_div_valid"}, 64'(div_valid), 64'd1);
            chk({nm, "_div_w"}, 64'(div_w), 64'(v.word));
            chk({nm, "_div_signed"}, 64'(div_signed), 64'(!v.op[0]));
            chk({nm, "_dividend"}, div_dividend, v.s1);
            chk({nm, "_divisor"}, div_divisor, v.s2);
            div_ready = 1'b1;
            step();
            div_ready = 1'b0;
            chk({nm, "_div_valid_drop"}, 64'(div_valid), 64'd0);
            step();
            step();
            chk({nm, "_busy_wait"}, 64'(busy), 64'd1);
            div_out_valid = 1'b1; div_quotient = v.quo; div_remainder = v.rem;
            step();
            div_out_valid = 1'b0; div_quotient = '0; div_remainder = '0;
        end
        chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_rsp_data"}, rsp_data, v.exp);
        chk({nm, "_rsp_tag"}, 64'(rsp_tag), 64'(v.tag));
        finish_rsp(nm);
    endtask

    initial begin
        vec_t v;
        // divw -7/2; core returns junk in the upper half
        vecs[0]  = mk(2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 1'b0,
                      64'h1234_5678_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD);
        vecs[1]  = mk(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 1'b0,
                      64'h0000_0000_FFFF_FFFD, 64'hABCD_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[2]  = mk(2'b01, 1'b0, 64'd100, 64'd0, 5'd3, 1'b1, '0, '0, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[3]  = mk(2'b11, 1'b0, 64'd100, 64'd0, 5'd4, 1'b1, '0, '0, 64'd100);
        vecs[4]  = mk(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1'b1,
                      '0, '0, 64'h8000_0000_0000_0000);
        vecs[5]  = mk(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 1'b1,
                      '0, '0, 64'd0);
        // divw overflow: result is the dividend sign-extended from bit 31
        vecs[6]  = mk(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd7, 1'b1,
                      '0, '0, 64'hFFFF_FFFF_8000_0000);
        // remuw by a divisor whose low word is zero
        vecs[7]  = mk(2'b11, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 5'd8, 1'b1,
                      '0, '0, 64'hFFFF_FFFF_8000_0001);
        vecs[8]  = mk(2'b01, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 5'd9, 1'b1,
                      '0, '0, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[9]  = mk(2'b01, 1'b0, 64'd9, 64'd4, 5'd10, 1'b0, 64'd2, 64'd1, 64'd2);
        vecs[10] = mk(2'b00, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFC, 5'd11, 1'b0,
                      64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
        // -2^63 / 1 is not an overflow and goes to the core
        vecs[11] = mk(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 5'd12, 1'b0,
                      64'h8000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000);

        #12;
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_div_valid", 64'(div_valid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_tag", 64'(rsp_tag), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Request together with flush is ignored.
        req_valid = 1'b1; flush = 1'b1; req_op = 2'b01; req_src1 = 64'd9; req_src2 = 64'd4;
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_req_busy", 64'(busy), 64'd0);
        chk("flush_req_div_valid", 64'(div_valid), 64'd0);

        // Flush in ISSUE before the core accepts: back to idle, no response.
        v = mk(2'b00, 1'b0, 64'd50, 64'd5, 5'd13, 1'b0, 64'd10, 64'd0, 64'd10);
        drive_req(v);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("issue_flush_div_valid", 64'(div_valid), 64'd0);
        chk("issue_flush_req_ready", 64'(req_ready), 64'd1);
        chk("issue_flush_rsp_valid", 64'(rsp_valid), 64'd0);

        // remu 1000/7 with response backpressure.
        v = mk(2'b11, 1'b0, 64'd1000, 64'd7, 5'd21, 1'b0, 64'd142, 64'd6, 64'd6);
        drive_req(v);
        div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        div_out_valid = 1'b1; div_quotient = v.quo; div_remainder = v.rem;
        step();
        div_out_valid = 1'b0; div_quotient = '0; div_remainder = 64'hDEAD;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp%0d_rsp_valid", k), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp%0d_rsp_data", k), rsp_data, 64'd6);
            chk($sformatf("bp%0d_rsp_tag", k), 64'(rsp_tag), 64'd21);
            chk($sformatf("bp%0d_req_ready", k), 64'(req_ready), 64'd0);
            if (k < 3) step();
        end
        finish_rsp("bp");

        // Flush five cycles after acceptance of div 50/5: drain the core result.
        v = mk(2'b00, 1'b0, 64'd50, 64'd5, 5'd14, 1'b0, 64'd10, 64'd0, 64'd10);
        drive_req(v);
        div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_req_ready", 64'(req_ready), 64'd0);
        step();
        div_out_valid = 1'b1; div_quotient = 64'd10; div_remainder = 64'd0;
        step();
        div_out_valid = 1'b0;
        chk("drain_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("drain_req_ready_after", 64'(req_ready), 64'd1);
        run_vec(vecs[9], "post_drain");

        // Stray result strobe while idle is ignored.
        div_out_valid = 1'b1; div_quotient = 64'd77;
        step();
        div_out_valid = 1'b0;
        chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);

        // Asynchronous reset while waiting on the core.
        drive_req(v);
        div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        step();
        #3 reset = 1'b1;
        #1;
        chk("arst_req_ready", 64'(req_ready), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_div_valid", 64'(div_valid), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("arst_rsp_tag", 64'(rsp_tag), 64'd0);
        chk("arst_div_dividend", div_dividend, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step();
        run_vec(vecs[10], "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
